data_sram_responder: RTL and testbench

- Responder (slave) end of the data-memory port driven by the pipeline's M stage.
- Accepts one request per handshake on a req/addr_ok/data_ok interface.
- Performs byte-lane writes or word reads on an internal word array.
- Returns completion after a parameterised latency. Used as the data memory model behind the core and as the base for the later cache refill path.

---
 rtl/data_sram_responder.sv | 162 ++++++++++++++++
 tb/tb_data_sram_responder.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_responder.sv
// Data-memory responder: req/addr_ok/data_ok port onto a word array.
// Optional alignment checking (err port) when DATA_SRAM_ALIGN_CHECK_EN is defined.
module data_sram_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
`ifdef DATA_SRAM_ALIGN_CHECK_EN
  ,
  output logic        err
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam state_t   GO_STATE = (LATENCY == 1) ? S_RESP : S_WAIT;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 2);

  logic [31:0] mem [2**ADDR_W];

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic ready_q;

  logic              wr_q;
  logic [ADDR_W-1:0] idx_q;
  logic [3:0]        wstrb_q;
  logic [31:0]       wdata_q;
  logic              mis_q, mis_d;
  logic [31:0]       hold_q;

  logic        accept;
  logic        commit;
  logic        rd_resp;
  logic [31:0] rd_word;

`ifdef DATA_SRAM_ALIGN_CHECK_EN
  // Misalignment of the incoming request, judged at accept time.
  always_comb begin
    mis_d = 1'b0;
    unique case (1'b1)
      (size == 2'd1): mis_d = addr[0];
      (size == 2'd2): mis_d = (addr[1:0] != 2'b00);
      (size == 2'd3): mis_d = 1'b1;
      default:        mis_d = 1'b0;
    endcase
  end

  assign err = data_ok & mis_q;

  logic unused_addr;
  assign unused_addr = ^addr[31:ADDR_W+2];
`else
  assign mis_d = 1'b0;

  logic unused_addr;
  assign unused_addr = ^{addr[31:ADDR_W+2], addr[1:0], size};
`endif

  assign addr_ok = ready_q & (state_q != S_WAIT);
  assign accept  = req & addr_ok;
  assign data_ok = (state_q == S_RESP);
  assign commit  = data_ok & wr_q & ~mis_q;
  assign rd_resp = data_ok & ~wr_q;
  assign rd_word = mis_q ? 32'h0 : mem[idx_q];
  assign rdata   = rd_resp ? rd_word : hold_q;

  // Next state and wait counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = GO_STATE;
          cnt_d   = CNT_INIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (accept) begin
          state_d = GO_STATE;
          cnt_d   = CNT_INIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counter and the one-cycle gate that blocks accepts at reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= 1'b1;
    end
  end

  // Latch the accepted request; reset drops anything pending.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wstrb_q <= 4'h0;
      wdata_q <= 32'h0;
      mis_q   <= 1'b0;
    end else if (accept) begin
      wr_q    <= wr;
      idx_q   <= addr[ADDR_W+1:2];
      wstrb_q <= wstrb;
      wdata_q <= wdata;
      mis_q   <= mis_d;
    end
  end

  // Read data holds the last response word between reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q <= 32'h0;
    end else if (rd_resp) begin
      hold_q <= rd_word;
    end
  end

  // Byte-lane write commit at the edge that ends RESP; array survives reset.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) begin
          mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: three instances at LATENCY 1, 2, 3.
// Directed vectors with hand-computed expectations.
module tb_data_sram_responder;

  localparam int AW = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_s;
  logic [2:0]  wr_s;
  logic [1:0]  size_s  [3];
  logic [31:0] addr_s  [3];
  logic [3:0]  wstrb_s [3];
  logic [31:0] wdata_s [3];
  logic [2:0]  addr_ok_s;
  logic [2:0]  data_ok_s;
  logic [31:0] rdata_s [3];
  logic [2:0]  err_s;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_sram_responder #(
      .ADDR_W (AW),
      .LATENCY(g + 1)
    ) u_dut (
      .clk    (clk),
      .rst    (rst),
      .req    (req_s[g]),
      .wr     (wr_s[g]),
      .size   (size_s[g]),
      .addr   (addr_s[g]),
      .wstrb  (wstrb_s[g]),
      .wdata  (wdata_s[g]),
      .addr_ok(addr_ok_s[g]),
      .data_ok(data_ok_s[g]),
      .rdata  (rdata_s[g])
`ifdef DATA_SRAM_ALIGN_CHECK_EN
      ,
      .err    (err_s[g])
`endif
    );
  end

`ifndef DATA_SRAM_ALIGN_CHECK_EN
  assign err_s = 3'b000;
`endif

  task automatic do_txn(
    input  int          d,
    input  logic        w,
    input  logic [1:0]  sz,
    input  logic [31:0] a,
    input  logic [3:0]  st,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output int          lat,
    output logic        e
  );
    int n;
    @(negedge clk);
    req_s[d]   = 1'b1;
    wr_s[d]    = w;
    size_s[d]  = sz;
    addr_s[d]  = a;
    wstrb_s[d] = st;
    wdata_s[d] = wd;
    n = 0;
    while (!addr_ok_s[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    req_s[d] = 1'b0;
    lat = 1;
    while (!data_ok_s[d] && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!data_ok_s[d]) lat = -1;
    rd = rdata_s[d];
    e  = err_s[d];
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (data_ok_s !== 3'b000) begin
      errs++;
      $display("FAIL reset_data_ok: got %b expected 000", data_ok_s);
    end
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (rdata_s[d] !== 32'h0) begin
        errs++;
        $display("FAIL reset_rdata[%0d]: got %h expected 0", d, rdata_s[d]);
      end
    end
    checks++;
    if (err_s !== 3'b000) begin
      errs++;
      $display("FAIL reset_err: got %b expected 000", err_s);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (addr_ok_s !== 3'b111) begin
      errs++;
      $display("FAIL release_addr_ok: got %b expected 111", addr_ok_s);
    end
  endtask

  task automatic test_word_rw();
    logic [31:0] rd;
    int lat;
    logic e;
    do_txn(1, 1'b1, 2'd2, 32'h100, 4'hF, 32'hDEADBEEF, rd, lat, e);
    checks++;
    if (lat !== 2) begin
      errs++;
      $display("FAIL word_wr_latency: got %0d expected 2", lat);
    end
    do_txn(1, 1'b0, 2'd2, 32'h100, 4'h0, 32'h0, rd, lat, e);
    checks++;
    if (lat !== 2) begin
      errs++;
      $display("FAIL word_rd_latency: got %0d expected 2", lat);
    end
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      errs++;
      $display("FAIL word_rd_data: got %h expected deadbeef", rd);
    end
  endtask

  task automatic test_byte_lane();
    logic [31:0] rd;
    int lat;
    logic e;
    do_txn(1, 1'b1, 2'd0, 32'h101, 4'b0010, 32'h0000_5500, rd, lat, e);
    do_txn(1, 1'b0, 2'd2, 32'h100, 4'h0, 32'h0, rd, lat, e);
    checks++;
    if (rd !== 32'hDEAD55EF) begin
      errs++;
      $display("FAIL byte_lane_rd: got %h expected dead55ef", rd);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rdata_s[1] !== 32'hDEAD55EF || data_ok_s[1] !== 1'b0) begin
      errs++;
      $display("FAIL rdata_hold: got %h ok=%b expected dead55ef ok=0",
               rdata_s[1], data_ok_s[1]);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    req_s[0]   = 1'b1;
    wr_s[0]    = 1'b1;
    size_s[0]  = 2'd2;
    addr_s[0]  = 32'h200;
    wstrb_s[0] = 4'hF;
    wdata_s[0] = 32'h12345678;
    checks++;
    if (addr_ok_s[0] !== 1'b1) begin
      errs++;
      $display("FAIL b2b_addr_ok0: got %b expected 1", addr_ok_s[0]);
    end
    @(posedge clk);
    #1;
    checks++;
    if (data_ok_s[0] !== 1'b1 || addr_ok_s[0] !== 1'b1) begin
      errs++;
      $display("FAIL b2b_wr_resp: got ok=%b aok=%b expected 1 1",
               data_ok_s[0], addr_ok_s[0]);
    end
    wr_s[0]    = 1'b0;
    wstrb_s[0] = 4'h0;
    @(posedge clk);
    #1;
    checks++;
    if (data_ok_s[0] !== 1'b1 || rdata_s[0] !== 32'h12345678) begin
      errs++;
      $display("FAIL b2b_rd: got ok=%b data=%h expected 1 12345678",
               data_ok_s[0], rdata_s[0]);
    end
    addr_s[0] = 32'h200 + 32'(4 * (2**AW));
    @(posedge clk);
    #1;
    checks++;
    if (data_ok_s[0] !== 1'b1 || rdata_s[0] !== 32'h12345678) begin
      errs++;
      $display("FAIL b2b_wrap_rd: got ok=%b data=%h expected 1 12345678",
               data_ok_s[0], rdata_s[0]);
    end
    req_s[0] = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (data_ok_s[0] !== 1'b0) begin
      errs++;
      $display("FAIL b2b_idle: got %b expected 0", data_ok_s[0]);
    end
  endtask

  task automatic test_misalign();
`ifdef DATA_SRAM_ALIGN_CHECK_EN
    logic [31:0] rd;
    int lat;
    logic e;
    do_txn(1, 1'b1, 2'd2, 32'h102, 4'hF, 32'hFFFFFFFF, rd, lat, e);
    checks++;
    if (e !== 1'b1 || lat !== 2) begin
      errs++;
      $display("FAIL mis_wr_err: got err=%b lat=%0d expected 1 2", e, lat);
    end
    do_txn(1, 1'b0, 2'd2, 32'h100, 4'h0, 32'h0, rd, lat, e);
    checks++;
    if (rd !== 32'hDEAD55EF || e !== 1'b0) begin
      errs++;
      $display("FAIL mis_unchanged: got %h err=%b expected dead55ef 0",
               rd, e);
    end
    do_txn(1, 1'b0, 2'd1, 32'h102, 4'h0, 32'h0, rd, lat, e);
    checks++;
    if (e !== 1'b0 || rd !== 32'hDEAD55EF) begin
      errs++;
      $display("FAIL half_rd: got %h err=%b expected dead55ef 0", rd, e);
    end
    do_txn(1, 1'b0, 2'd2, 32'h101, 4'h0, 32'h0, rd, lat, e);
    checks++;
    if (e !== 1'b1 || rd !== 32'h0) begin
      errs++;
      $display("FAIL mis_rd: got %h err=%b expected 0 1", rd, e);
    end
    @(posedge clk);
    #1;
    checks++;
    if (err_s[1] !== 1'b0) begin
      errs++;
      $display("FAIL err_idle: got %b expected 0", err_s[1]);
    end
`endif
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd;
    int lat;
    logic e;
    do_txn(2, 1'b1, 2'd2, 32'h300, 4'hF, 32'hA5A5A5A5, rd, lat, e);
    checks++;
    if (lat !== 3) begin
      errs++;
      $display("FAIL lat3_wr: got %0d expected 3", lat);
    end
    @(negedge clk);
    req_s[2]   = 1'b1;
    wr_s[2]    = 1'b1;
    addr_s[2]  = 32'h300;
    wstrb_s[2] = 4'hF;
    wdata_s[2] = 32'h0BADF00D;
    @(posedge clk);
    #1;
    req_s[2] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      checks++;
      if (data_ok_s !== 3'b000) begin
        errs++;
        $display("FAIL abort_data_ok: got %b expected 000", data_ok_s);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (data_ok_s[2] !== 1'b0) begin
      errs++;
      $display("FAIL abort_release: got %b expected 0", data_ok_s[2]);
    end
    do_txn(2, 1'b0, 2'd2, 32'h300, 4'h0, 32'h0, rd, lat, e);
    checks++;
    if (rd !== 32'hA5A5A5A5 || lat !== 3) begin
      errs++;
      $display("FAIL abort_readback: got %h lat=%0d expected a5a5a5a5 3",
               rd, lat);
    end
  endtask

  initial begin
    rst   = 1'b0;
    req_s = 3'b000;
    wr_s  = 3'b000;
    for (int d = 0; d < 3; d++) begin
      size_s[d]  = 2'd2;
      addr_s[d]  = 32'h0;
      wstrb_s[d] = 4'h0;
      wdata_s[d] = 32'h0;
    end
    test_reset();
    test_word_rw();
    test_byte_lane();
    test_back_to_back();
    test_misalign();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
